pred_ctx_seq: RTL and testbench
===============================

Name: pred_ctx_seq

Overview:
- Context sequencer and initiator for the PE predicate register file.
- Holds a small context memory of predicate-path control words.
- Once started, issues one word per cycle: mux select, write/read/send addresses, demux enables, FU-source select, write-back strobe. Loops a programmed number of iterations.
- Sits beside the predicate register file in each PE. Outputs are registered on the rising CLK edge so the register file's falling-edge write sees stable values.

Parameters:
- DEPTH, 16, number of context words.
- AW, 4, context address width; DEPTH = 2**AW.
- ITER_W, 8, iteration counter width.
- SCRATCH, 6'd63, register-file entry used as a write sink when idle.

Ports:
- CLK in 1 clock; all state updates on the rising edge.
- RST_N in 1 asynchronous active-low reset.
- cfg_we in 1 context write strobe.
- cfg_addr in AW context write address.
- cfg_data in 47 context word. Layout: [46] write_back_p, [45:37] control_in_p, [36:31] control_put_in_p, [30:25] control_put_out_p, [24:19] control_pred, [18:13] control_send_p, [12:4] control_out_p, [3:0] control_pe2fu_p.
- start in 1 run request, sampled in IDLE only.
- ctx_last in AW index of the last context per iteration; latched at start.
- iter_num in ITER_W iteration count; latched at start.
- stall in 1 freeze sequencing.
- busy out 1 high in RUN.
- done out 1 one-cycle completion pulse.
- ctx_pc out AW context index currently driven.
- iter_cnt out ITER_W current iteration index.
- write_back_p out 1, control_in_p out 9, control_put_in_p out 6, control_put_out_p out 6, control_pred out 6, control_send_p out 6, control_out_p out 9, control_pe2fu_p out 4: registered context fields.

Behaviour:
- NOP word: write_back_p=0, control_in_p=0, control_put_in_p=SCRATCH, control_put_out_p=SCRATCH, control_pred=0, control_send_p=0, control_out_p=0, control_pe2fu_p=4'b1111.
  - 4'b1111 forces pred_out to 0.
  - SCRATCH absorbs the register file's unconditional put-in write.
- Reset: state=IDLE, all control outputs = NOP, busy=0, done=0, ctx_pc=0, iter_cnt=0. Context memory is not reset; its contents are undefined until written.
- Config write: cfg_we in IDLE or DONE writes mem[cfg_addr] <= cfg_data at the edge. cfg_we in RUN is dropped.
- IDLE:
  - start=1 with iter_num!=0: latch ctx_last/iter_num, outputs <= mem[0], ctx_pc=0, iter_cnt=0, go RUN. Context 0 is visible the cycle after start.
  - start=1 with iter_num==0: go DONE with no context issued.
- RUN, stall=0, each edge:
  - ctx_pc<ctx_last: ctx_pc++, outputs <= mem[ctx_pc+1].
  - ctx_pc==ctx_last and iter_cnt<iter_num-1: ctx_pc=0, iter_cnt++, outputs <= mem[0].
  - ctx_pc==ctx_last and iter_cnt==iter_num-1: outputs <= NOP, go DONE.
- RUN, stall=1: outputs <= NOP; ctx_pc and iter_cnt hold. At the first edge after stall falls, outputs <= mem[ctx_pc], re-issuing the interrupted context. Sequencing then resumes.
- DONE: done=1 and busy=0 for exactly one cycle, outputs NOP, then IDLE.
- start in RUN or DONE is ignored.
- Total issued cycles without stall = (ctx_last+1)*iter_num. ctx_last=0 is legal and issues the single context every cycle.
- iter_cnt wraps never; the maximum iteration count is 2**ITER_W-1.
- RST_N low in any state: immediate return to reset values without waiting for a clock.

Test Plan:
- Reset, no start → outputs = NOP: control_put_in_p=63, control_pe2fu_p=4'b1111, busy=0, done=0.
- Load mem[0..2] with distinct words. start with ctx_last=2, iter_num=2 → outputs mem0,mem1,mem2,mem0,mem1,mem2 on consecutive cycles, then NOP; done pulses exactly once, 7 cycles after start.
- Same program with stall high for 3 cycles while mem1 is driven → NOP for 3 cycles, then mem1 re-issued, then mem2; iter_cnt unchanged during the stall.
- start with iter_num=0 → done pulse the next cycle; outputs never leave NOP.
- cfg_we to addr 1 during RUN → mem[1] unchanged on the next iteration. Write in IDLE → new value issued on the next run.
- Assert RST_N low mid-run, between edges → outputs = NOP and busy=0 immediately. A later start replays from ctx 0.

Source files
------------

// File: rtl/pred_ctx_if.sv
// rtl/pred_ctx_if.sv - configuration, run-control and context-output bundle for pred_ctx_seq
interface pred_ctx_if #(
  parameter int AW     = 4,
  parameter int ITER_W = 8
);
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [46:0]       cfg_data;
  logic              start;
  logic [AW-1:0]     ctx_last;
  logic [ITER_W-1:0] iter_num;
  logic              stall;
  logic              busy;
  logic              done;
  logic [AW-1:0]     ctx_pc;
  logic [ITER_W-1:0] iter_cnt;
  logic              write_back_p;
  logic [8:0]        control_in_p;
  logic [5:0]        control_put_in_p;
  logic [5:0]        control_put_out_p;
  logic [5:0]        control_pred;
  logic [5:0]        control_send_p;
  logic [8:0]        control_out_p;
  logic [3:0]        control_pe2fu_p;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, ctx_last, iter_num, stall,
    input  busy, done, ctx_pc, iter_cnt, write_back_p, control_in_p,
           control_put_in_p, control_put_out_p, control_pred, control_send_p,
           control_out_p, control_pe2fu_p
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, ctx_last, iter_num, stall,
    output busy, done, ctx_pc, iter_cnt, write_back_p, control_in_p,
           control_put_in_p, control_put_out_p, control_pred, control_send_p,
           control_out_p, control_pe2fu_p
  );
endinterface

// File: rtl/pred_ctx_seq.sv
// rtl/pred_ctx_seq.sv - context sequencer driving the PE predicate register file controls
module pred_ctx_seq #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter int         ITER_W  = 8,
  parameter logic [5:0] SCRATCH = 6'd63
) (
  input  logic     CLK,
  input  logic     RST_N,
  pred_ctx_if.slave bus
);

  // Idle word: no write-back, pred_out forced to 0, put-in write parked on SCRATCH
  localparam logic [46:0] NOP = {1'b0, 9'd0, SCRATCH, SCRATCH, 6'd0, 6'd0, 9'd0, 4'b1111};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [46:0]       mem [DEPTH];
  logic [46:0]       word;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     pc_inc;
  logic [AW-1:0]     last;
  logic [ITER_W-1:0] it;
  logic [ITER_W-1:0] num;
  logic              stalled;
  logic              busy_r;
  logic              done_r;

  assign pc_inc = pc + AW'(1);

  // Context memory: writable only while not sequencing, never reset
  always_ff @(posedge CLK) begin
    if (bus.cfg_we && state != S_RUN) mem[bus.cfg_addr] <= bus.cfg_data;
  end

  // Sequencer FSM; all outputs registered so the falling-edge register-file write sees stable values
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      word    <= NOP;
      pc      <= '0;
      it      <= '0;
      last    <= '0;
      num     <= '0;
      stalled <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            if (bus.iter_num != '0) begin
              last    <= bus.ctx_last;
              num     <= bus.iter_num;
              pc      <= '0;
              it      <= '0;
              word    <= mem[0];
              stalled <= 1'b0;
              busy_r  <= 1'b1;
              state   <= S_RUN;
            end else begin
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (bus.stall) begin
            // Freeze position; the interrupted context is re-issued once stall drops
            word    <= NOP;
            stalled <= 1'b1;
          end else if (stalled) begin
            word    <= mem[pc];
            stalled <= 1'b0;
          end else if (pc < last) begin
            pc   <= pc_inc;
            word <= mem[pc_inc];
          end else if (it != num - ITER_W'(1)) begin
            pc   <= '0;
            it   <= it + ITER_W'(1);
            word <= mem[0];
          end else begin
            word   <= NOP;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.ctx_pc   = pc;
  assign bus.iter_cnt = it;
  assign {bus.write_back_p, bus.control_in_p, bus.control_put_in_p, bus.control_put_out_p,
          bus.control_pred, bus.control_send_p, bus.control_out_p, bus.control_pe2fu_p} = word;

endmodule

// File: tb/tb_pred_ctx_seq.sv
// tb/tb_pred_ctx_seq.sv - scoreboard bench for pred_ctx_seq
module tb_pred_ctx_seq;
  localparam int AW = 4;
  localparam int ITER_W = 8;
  localparam logic [46:0] NOP = {1'b0, 9'd0, 6'd63, 6'd63, 6'd0, 6'd0, 9'd0, 4'b1111};

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  pred_ctx_if #(.AW(AW), .ITER_W(ITER_W)) bus ();

  pred_ctx_seq #(.DEPTH(16), .AW(AW), .ITER_W(ITER_W), .SCRATCH(6'd63)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );

  typedef struct {
    logic [46:0]       w;
    logic              b;
    logic              d;
    logic              chk;
    logic [AW-1:0]     pc;
    logic [ITER_W-1:0] it;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [46:0] mdl_mem [16];

  function automatic logic [46:0] act_word();
    return {bus.write_back_p, bus.control_in_p, bus.control_put_in_p, bus.control_put_out_p,
            bus.control_pred, bus.control_send_p, bus.control_out_p, bus.control_pe2fu_p};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [46:0] w, input logic b, input logic d, input logic chk,
                      input int pc, input int it);
    exp_t e;
    e.w = w; e.b = b; e.d = d; e.chk = chk;
    e.pc = AW'(pc); e.it = ITER_W'(it);
    sb.push_back(e);
  endtask

  // Monitor: one expected entry per clock while the scoreboard holds work
  always @(negedge CLK) begin
    if (RST_N && sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("word", 64'(act_word()), 64'(mon_e.w));
      check("busy", 64'(bus.busy), 64'(mon_e.b));
      check("done", 64'(bus.done), 64'(mon_e.d));
      if (mon_e.chk) begin
        check("ctx_pc", 64'(bus.ctx_pc), 64'(mon_e.pc));
        check("iter_cnt", 64'(bus.iter_cnt), 64'(mon_e.it));
      end
    end
  end

  task automatic cfg_write(input int a, input logic [46:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = AW'(a);
    bus.cfg_data = d;
    @(posedge CLK); #1;
    bus.cfg_we = 1'b0;
    mdl_mem[a] = d;
  endtask

  function automatic logic [46:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[46:0];
  endfunction

  // mode: 0 no stall, 1 stall on edges 2..4, 2 random stall
  task automatic run(input int last, input int n, input int mode, input bit cfg_mid, input int abort_at);
    bit st [512];
    int pcq [$];
    int itq [$];
    int idx, j, ne;
    bit stl, fin;
    for (int k = 0; k < 512; k++)
      st[k] = (mode == 1) ? (k >= 2 && k <= 4) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    bus.start = 1'b1;
    bus.ctx_last = AW'(last);
    bus.iter_num = ITER_W'(n);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    ne = sb.size();
    if (n == 0) begin
      push(NOP, 0, 1, 0, 0, 0);
    end else begin
      for (int i = 0; i < n; i++)
        for (int c = 0; c <= last; c++) begin
          pcq.push_back(c);
          itq.push_back(i);
        end
      push(mdl_mem[0], 1, 0, 1, 0, 0);
      idx = 0; stl = 0; fin = 0; j = 1;
      while (!fin && j < 500) begin
        if (st[j]) begin
          push(NOP, 1, 0, 1, pcq[idx], itq[idx]);
          stl = 1;
        end else if (stl) begin
          stl = 0;
          push(mdl_mem[pcq[idx]], 1, 0, 1, pcq[idx], itq[idx]);
        end else begin
          idx++;
          if (idx == pcq.size()) begin
            push(NOP, 0, 1, 0, 0, 0);
            fin = 1;
          end else begin
            push(mdl_mem[pcq[idx]], 1, 0, 1, pcq[idx], itq[idx]);
          end
        end
        j++;
      end
    end
    push(NOP, 0, 0, 0, 0, 0);
    ne = sb.size() - ne;
    for (int k = 1; k < ne; k++) begin
      bus.stall = st[k];
      if (cfg_mid && k == 1) begin
        bus.cfg_we = 1'b1;
        bus.cfg_addr = AW'(1);
        bus.cfg_data = rand_word();
      end
      if (k == 2) bus.cfg_we = 1'b0;
      @(posedge CLK); #1;
      if (k == abort_at) begin
        #2 RST_N = 1'b0;
        #1;
        check("abort_word", 64'(act_word()), 64'(NOP));
        check("abort_busy", 64'(bus.busy), 64'(0));
        sb.delete();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        bus.stall = 1'b0;
        bus.cfg_we = 1'b0;
        return;
      end
    end
    bus.stall = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.start = 1'b0;
    bus.ctx_last = '0;
    bus.iter_num = '0;
    bus.stall = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    check("rst_word", 64'(act_word()), 64'(NOP));
    check("rst_put_in", 64'(bus.control_put_in_p), 64'(63));
    check("rst_pe2fu", 64'(bus.control_pe2fu_p), 64'(4'b1111));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_pc", 64'(bus.ctx_pc), 64'(0));
    check("rst_iter", 64'(bus.iter_cnt), 64'(0));

    for (int a = 0; a < 16; a++) cfg_write(a, rand_word());

    run(2, 2, 0, 0, 0);
    run(2, 2, 1, 0, 0);
    run(5, 0, 0, 0, 0);
    run(2, 2, 0, 1, 0);
    cfg_write(1, rand_word());
    run(2, 2, 0, 0, 0);
    run(0, 5, 0, 0, 0);
    run(15, 1, 2, 0, 0);
    for (int k = 0; k < 6; k++)
      run($urandom_range(0, 15), $urandom_range(0, 4), 2, 0, 0);
    run(3, 3, 0, 0, 4);
    run(3, 1, 0, 0, 0);

    repeat (3) @(posedge CLK);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
